// File: rtl/multi_digit_counter.sv
// Multi-digit BCD up/down counter with debounced direction/run buttons
// and a multiplexed, active-low seven-segment display driver.

module multi_digit_counter #(
    parameter int DIGITS    = 4,
    parameter int TICK_DIV  = 100000000,
    parameter int DB_CYCLES = 1000000,
    parameter int SCAN_DIV  = 100000
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  btn_dir,
    input  logic                  btn_run,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  dir,
    output logic                  running,
    output logic                  wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b1111111;
        endcase
        return pattern;
    endfunction

    // Bit 0 is the direction button, bit 1 the run button.
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_run, btn_dir};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic          sync_a;
        logic          sync_b;
        logic          level;
        logic          level_q;
        logic [DW-1:0] run_cnt;

        // A level flips only after DB_CYCLES consecutive disagreeing samples.
        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                sync_a  <= 1'b0;
                sync_b  <= 1'b0;
                level   <= 1'b0;
                level_q <= 1'b0;
                run_cnt <= '0;
            end else begin
                sync_a  <= btn_raw[b];
                sync_b  <= sync_a;
                level_q <= level;
                if (sync_b != level) begin
                    if (run_cnt == DB_LAST) begin
                        level   <= sync_b;
                        run_cnt <= '0;
                    end else begin
                        run_cnt <= run_cnt + DW'(1);
                    end
                end else begin
                    run_cnt <= '0;
                end
            end
        end

        assign press[b] = level & ~level_q;
    end

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    // Ripple the carry/borrow from digit 0; carry out of the top digit means wrap.
    logic [4*DIGITS-1:0] bcd_next;
    logic                carry;

    always_comb begin
        bcd_next = bcd;
        carry    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (dir) begin
                    if (bcd[4*i +: 4] >= 4'd9) begin
                        bcd_next[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_next[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (bcd[4*i +: 4] == 4'd0) begin
                        bcd_next[4*i +: 4] = 4'd9;
                    end else if (bcd[4*i +: 4] > 4'd9) begin
                        bcd_next[4*i +: 4] = 4'd9;
                        carry              = 1'b0;
                    end else begin
                        bcd_next[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bcd     <= '0;
            wrap    <= 1'b0;
            dir     <= 1'b1;
            running <= 1'b1;
        end else begin
            wrap <= 1'b0;
            if (tick && running) begin
                bcd  <= bcd_next;
                wrap <= carry;
            end
            dir     <= dir ^ press[0];
            running <= running ^ press[1];
        end
    end

    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] scan_idx;
    logic [3:0]    cur_digit;

    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                cur_digit = bcd[4*i +: 4];
            end
        end
    end

    // an and seg are registered together so they always describe the same digit.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            an       <= ~DIGITS'(1);
            seg      <= 7'b1000000;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
            an  <= ~(DIGITS'(1) << scan_idx);
            seg <= seg_decode(cur_digit);
        end
    end

endmodule

// File: tb/tb_multi_digit_counter.sv
// Randomized bench for multi_digit_counter, checked cycle by cycle against
// an arithmetic model of the counter, debouncers and display scan.

module tb_multi_digit_counter;

    localparam int DIGITS    = 2;
    localparam int TICK_DIV  = 10;
    localparam int DB_CYCLES = 4;
    localparam int SCAN_DIV  = 3;
    localparam int MOD       = 100;

    logic                clk = 1'b0;
    logic                clr = 1'b1;
    logic                btn_dir = 1'b0;
    logic                btn_run = 1'b0;
    logic [4*DIGITS-1:0] bcd;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic                dir;
    logic                running;
    logic                wrap;

    always #5 clk = ~clk;

    multi_digit_counter #(
        .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk), .clr(clr), .btn_dir(btn_dir), .btn_run(btn_run),
        .bcd(bcd), .seg(seg), .an(an), .dir(dir), .running(running), .wrap(wrap)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    logic [6:0] segTable [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    // Model state: counter value as a plain integer, cycles since reset, button history.
    int                nCyc;
    int                val;
    bit                mDir, mRun, mWrap;
    bit                pend [2];
    bit                s1 [2];
    bit                s2 [2];
    bit                lvl [2];
    bit                hist [2][DB_CYCLES];
    logic [DIGITS-1:0] expAn;
    logic [6:0]        expSeg;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int digitOf(input int v, input int i);
        int d = 1;
        for (int k = 0; k < i; k++) d = d * 10;
        return (v / d) % 10;
    endfunction

    function automatic logic [4*DIGITS-1:0] toBcd(input int v);
        logic [4*DIGITS-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'(digitOf(v, i));
        return r;
    endfunction

    task automatic modelReset();
        nCyc = 0; val = 0; mDir = 1'b1; mRun = 1'b1; mWrap = 1'b0;
        for (int b = 0; b < 2; b++) begin
            pend[b] = 1'b0; s1[b] = 1'b0; s2[b] = 1'b0; lvl[b] = 1'b0;
            for (int j = 0; j < DB_CYCLES; j++) hist[b][j] = 1'b0;
        end
        expAn  = ~DIGITS'(1);
        expSeg = segTable[0];
    endtask

    task automatic modelStep();
        bit btn [2];
        bit rise [2];
        bit allDiffer;
        int idxPre;
        btn[0] = btn_dir;
        btn[1] = btn_run;
        idxPre = (nCyc / SCAN_DIV) % DIGITS;
        expAn  = ~(DIGITS'(1) << idxPre);
        expSeg = segTable[digitOf(val, idxPre)];
        mWrap = 1'b0;
        if ((nCyc % TICK_DIV) == TICK_DIV - 1 && mRun) begin
            if (mDir) begin
                mWrap = (val == MOD - 1);
                val   = (val + 1) % MOD;
            end else begin
                mWrap = (val == 0);
                val   = (val + MOD - 1) % MOD;
            end
        end
        mDir = mDir ^ pend[0];
        mRun = mRun ^ pend[1];
        for (int b = 0; b < 2; b++) begin
            for (int j = DB_CYCLES - 1; j > 0; j--) hist[b][j] = hist[b][j-1];
            hist[b][0] = s2[b];
            allDiffer = 1'b1;
            for (int j = 0; j < DB_CYCLES; j++) if (hist[b][j] == lvl[b]) allDiffer = 1'b0;
            rise[b] = 1'b0;
            if (allDiffer) begin
                lvl[b]  = ~lvl[b];
                rise[b] = lvl[b];
            end
            s2[b]   = s1[b];
            s1[b]   = btn[b];
            pend[b] = rise[b];
        end
        nCyc++;
    endtask

    task automatic compareAll();
        checkOutput("bcd",     32'(bcd),     32'(toBcd(val)));
        checkOutput("dir",     32'(dir),     32'(mDir));
        checkOutput("running", 32'(running), 32'(mRun));
        checkOutput("wrap",    32'(wrap),    32'(mWrap));
        checkOutput("an",      32'(an),      32'(expAn));
        checkOutput("seg",     32'(seg),     32'(expSeg));
    endtask

    // Entered and left at a falling edge; inputs change only there.
    task automatic applyStimulus(input bit bd, input bit br, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            btn_dir = bd;
            btn_run = br;
            @(posedge clk);
            modelStep();
            #1;
            compareAll();
            @(negedge clk);
        end
    endtask

    initial begin
        int mode, len;
        modelReset();
        #1 clr = 1'b0;
        #1;
        compareAll();
        checkOutput("rst_an",  32'(an),  32'(2'b10));
        checkOutput("rst_seg", 32'(seg), 32'(7'b1000000));
        @(negedge clk);
        clr = 1'b1;

        applyStimulus(1'b0, 1'b0, 990);
        checkOutput("up_99", 32'(bcd), 32'(8'h99));
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("up_wrap_bcd",  32'(bcd),  32'(8'h00));
        checkOutput("up_wrap_flag", 32'(wrap), 32'(1'b1));

        applyStimulus(1'b1, 1'b0, 8);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("down_dir", 32'(dir), 32'(1'b0));
        checkOutput("down_bcd", 32'(bcd), 32'(8'h99));

        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'(k % 2 == 0), 2);
        applyStimulus(1'b0, 1'b0, 8);
        checkOutput("bounce_running", 32'(running), 32'(1'b1));

        applyStimulus(1'b0, 1'b1, 6);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("pause_running", 32'(running), 32'(1'b0));
        applyStimulus(1'b0, 1'b0, 50);
        applyStimulus(1'b0, 1'b1, 6);
        applyStimulus(1'b0, 1'b0, 30);
        checkOutput("resume_running", 32'(running), 32'(1'b1));

        for (int e = 0; e < 60; e++) begin
            mode = int'($urandom_range(0, 3));
            len  = int'($urandom_range(1, 12));
            case (mode)
                0: applyStimulus(1'b0, 1'b0, len * 3);
                1: applyStimulus(1'b1, 1'b0, len);
                2: applyStimulus(1'b0, 1'b1, len);
                default: begin
                    for (int k = 0; k < len; k++)
                        applyStimulus(1'(k % 2), 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
                end
            endcase
        end

        btn_dir = 1'b0;
        btn_run = 1'b0;
        #2 clr = 1'b0;
        #1;
        modelReset();
        compareAll();
        checkOutput("arst_an", 32'(an), 32'(2'b10));
        @(negedge clk);
        clr = 1'b1;

        for (int e = 0; e < 30; e++) begin
            len = int'($urandom_range(1, 10));
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), len);
            applyStimulus(1'b0, 1'b0, len * 2);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
